// File: rtl/clk_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_rst_pkg                                                  |
// | Description : Shared types and defaults for the clock/reset generator:     |
// |               sequencer state enum, fractional clock-enable defaults and   |
// |               a helper sizing the shared lock/hold counter.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  // 42.857142 MHz system clock divided down to 0.894886 MHz CPU enables.
  localparam int CE_NUM_DEFAULT = 894886;
  localparam int CE_DEN_DEFAULT = 42857142;

  // Width for a counter that must reach max(a,b)-1 without wrapping.
  // Never returns zero so the counter always exists as a real vector.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/frac_ce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : frac_ce                                                      |
// | Description : Fractional clock-enable generator. Adds CE_NUM per cycle     |
// |               modulo CE_DEN; a wrap yields ce_p, crossing the half-way     |
// |               point yields ce_n. Held cleared while run is low.            |
// | Ports       : clk_sys - system clock                                       |
// |               rst_n   - asynchronous active-low reset                      |
// |               run     - accumulate enable (sequencer in RUN)               |
// |               ce_p    - single-cycle rising-phase enable                   |
// |               ce_n    - single-cycle falling-phase enable                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module frac_ce
  import clk_rst_pkg::*;
#(
  parameter int CE_NUM = CE_NUM_DEFAULT,
  parameter int CE_DEN = CE_DEN_DEFAULT,
  parameter int ACC_W  = 26
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic run,
  output logic ce_p,
  output logic ce_n
);

  localparam logic [ACC_W-1:0] C_NUM  = ACC_W'(CE_NUM);
  localparam logic [ACC_W-1:0] C_DEN  = ACC_W'(CE_DEN);
  localparam logic [ACC_W-1:0] C_HALF = ACC_W'(CE_DEN / 2);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_nxt;
  logic             r_ce_p;
  logic             r_ce_n;

  // ACC_W is chosen so acc + CE_NUM never overflows; the wrap subtracts the
  // exact modulus, so no phase error accumulates over time.
  assign w_nxt = r_acc + C_NUM;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ce_p <= 1'b0;
      r_ce_n <= 1'b0;
    end else if (!run) begin
      r_acc  <= '0;
      r_ce_p <= 1'b0;
      r_ce_n <= 1'b0;
    end else if (w_nxt >= C_DEN) begin
      r_acc  <= w_nxt - C_DEN;
      r_ce_p <= 1'b1;
      r_ce_n <= 1'b0;
    end else begin
      r_acc  <= w_nxt;
      r_ce_p <= 1'b0;
      r_ce_n <= (r_acc < C_HALF) && (w_nxt >= C_HALF);
    end
  end

  // A pulse registered on the last RUN cycle must not leak into the first
  // non-RUN cycle, so the registered pulses are qualified by run.
  assign ce_p = r_ce_p & run;
  assign ce_n = r_ce_n & run;

endmodule : frac_ce
`default_nettype wire

// File: rtl/clk_rst_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_rst_gen                                                  |
// | Description : PLL-lock qualified core reset sequencer with fractional CPU  |
// |               clock-enable generation.                                     |
// | Ports       : clk_sys    - system clock                                    |
// |               rst_n      - asynchronous active-low reset                   |
// |               pll_locked - PLL lock, asynchronous to clk_sys               |
// |               reset_req  - synchronous level core-reset request            |
// |               core_reset - registered active-high core reset               |
// |               ce_p/ce_n  - CPU clock-enables, rising/falling phase         |
// |               ready      - high while the sequencer is in RUN              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clk_rst_gen
  import clk_rst_pkg::*;
#(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 64,
  parameter int CE_NUM      = CE_NUM_DEFAULT,
  parameter int CE_DEN      = CE_DEN_DEFAULT,
  parameter int ACC_W       = 26
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic reset_req,
  output logic core_reset,
  output logic ce_p,
  output logic ce_n,
  output logic ready
);

  localparam int               CNT_W     = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       r_sync;
  logic             w_lk;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_core_reset;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], pll_locked};
  end

  assign w_lk = r_sync[1];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_cnt        <= '0;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      // Registered from the next state so it falls exactly on the first RUN
      // cycle; reset release cannot produce a low glitch since the flop only
      // changes on a clock edge.
      r_core_reset <= (w_state_nxt != RUN);
    end
  end

  // Lock loss overrides everything. In HOLD a request restarts the count
  // even on the final count cycle. The counter is cleared on every state
  // change, so it never needs to reach more than max(LOCK,HOLD)-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!w_lk) begin
      w_state_nxt = WAIT_LOCK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          w_cnt_nxt   = '0;
          w_state_nxt = STABLE;
        end
        STABLE: begin
          if (r_cnt == LOCK_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (reset_req) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          w_cnt_nxt = '0;
          if (reset_req) w_state_nxt = HOLD;
        end
        default: begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign ready      = (r_state == RUN);
  assign core_reset = r_core_reset;

  frac_ce #(
    .CE_NUM (CE_NUM),
    .CE_DEN (CE_DEN),
    .ACC_W  (ACC_W)
  ) u_frac_ce (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .run     (ready),
    .ce_p    (ce_p),
    .ce_n    (ce_n)
  );

endmodule : clk_rst_gen
`default_nettype wire
